ha_gl: RTL and testbench
========================

HA_GL -- requirements
Module: ha_gl

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the carry-event and operation counters (legal range 4..32).
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit, is the reset; asynchronous, active-low.
REQ-004 Port a, input, 1 bit, is addend A.
REQ-005 Port b, input, 1 bit, is addend B.
REQ-006 Port en, input, 1 bit, is the capture enable for the registered outputs and counters.
REQ-007 Port clr, input, 1 bit, is the synchronous clear of the statistics counters.
REQ-008 Port sum, output, 1 bit, is combinational a XOR b.
REQ-009 Port cout, output, 1 bit, is combinational a AND b.
REQ-010 Port sum_q, output, 1 bit, is the registered sum.
REQ-011 Port cout_q, output, 1 bit, is the registered cout.
REQ-012 Port valid_q, output, 1 bit, is high the cycle after any en=1 capture.
REQ-013 Port carry_cnt, output, CNT_W bits, is the count of captured operations with cout=1.
REQ-014 Port op_cnt, output, CNT_W bits, is the count of captured operations.

Function
REQ-015 sum and cout SHALL be built from gate primitives only (one XOR, one AND), with no dependence on clk, reset_n, en or clr.
REQ-016 Truth table SHALL be: 00->cout 0, sum 0; 01->0,1; 10->0,1; 11->1,0.
REQ-017 sum and cout SHALL settle within 1 time unit of an input change; reset_n low SHALL NOT affect them.
REQ-018 On a rising clk edge with en=1, sum_q/cout_q SHALL load sum/cout; with en=0 they SHALL hold.
REQ-019 valid_q SHALL equal en registered (one-cycle latency).
REQ-020 With en=1, op_cnt SHALL increment by 1; with en=1 and cout=1, carry_cnt SHALL also increment by 1.
REQ-021 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 clr=1 SHALL zero both counters at the next edge and SHALL take priority over a simultaneous increment; clr SHALL NOT affect sum_q, cout_q or valid_q.
REQ-023 carry_cnt SHALL never exceed op_cnt.

Reset
REQ-024 reset_n low SHALL immediately force sum_q=0, cout_q=0, valid_q=0, carry_cnt=0, op_cnt=0, regardless of clk.
REQ-025 On reset_n deassertion, the first capture SHALL occur at the first rising edge with en=1; reset asserted mid-operation SHALL discard any pending capture.

Configuration
REQ-026 Macro HA_GL_STATS_EN SHALL control the statistics block; when defined, carry_cnt, op_cnt and clr SHALL behave as in REQ-020..REQ-023.
REQ-027 When HA_GL_STATS_EN is undefined, the counters SHALL NOT be instantiated, carry_cnt and op_cnt SHALL be tied to 0, clr SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Exhaustive combinational check, no clock, reset_n=0: (a,b)=00,01,10,11 -> (cout,sum)=00,01,01,10, each checked 1 time unit after applying.
REQ-029 Registered path: reset_n 0->1; a=1, b=1, en=1 for one edge -> next cycle sum_q=0, cout_q=1, valid_q=1; then en=0 -> outputs hold and valid_q=0.
REQ-030 Counters (HA_GL_STATS_EN defined): apply 00,01,10,11,11 with en=1 -> op_cnt=5, carry_cnt=2; then assert clr together with en=1 and a=b=1 -> both counters 0.
REQ-031 Saturation: CNT_W=4, 20 captures of a=b=1 -> op_cnt=15, carry_cnt=15, both holding at 15.
REQ-032 Asynchronous reset: drive reset_n low between clock edges after several captures -> all registered outputs and counters 0 immediately, while sum/cout still follow a, b.
REQ-033 Macro undefined: same stimulus as REQ-030 -> carry_cnt=0 and op_cnt=0 throughout, and sum_q/cout_q match REQ-029.

Source files
------------

// File: rtl/ha_gl.sv
// ha_gl: gate-level half adder with registered outputs and optional
// capture statistics (carry-event and operation counters).
// Define HA_GL_STATS_EN to build the statistics counters; without it
// carry_cnt/op_cnt are tied to zero and clr is ignored.
module ha_gl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] op_cnt
);

  // The adder itself is two primitives so it stays purely combinational
  // and independent of clock, reset and the enables.
  xor uSumGate  (sum,  a, b);
  and uCoutGate (cout, a, b);

  logic sum_d;
  logic cout_d;

  // Next-state for the captured result: load on en, otherwise hold.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (en) begin
      sum_d  = sum;
      cout_d = cout;
    end
  end

  // Result and valid registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= en;
    end
  end

`ifdef HA_GL_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] opCnt_q;
  logic [CNT_W-1:0] opCnt_d;
  logic [CNT_W-1:0] carryCnt_q;
  logic [CNT_W-1:0] carryCnt_d;

  // Saturating counters; clr wins over any increment in the same cycle.
  // carry_cnt only counts when a capture happens, so it can never pass op_cnt.
  always_comb begin
    opCnt_d    = opCnt_q;
    carryCnt_d = carryCnt_q;
    if (clr) begin
      opCnt_d    = '0;
      carryCnt_d = '0;
    end else if (en) begin
      if (opCnt_q != CntMax) begin
        opCnt_d = opCnt_q + 1'b1;
      end
      if (cout && (carryCnt_q != CntMax)) begin
        carryCnt_d = carryCnt_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opCnt_q    <= '0;
      carryCnt_q <= '0;
    end else begin
      opCnt_q    <= opCnt_d;
      carryCnt_q <= carryCnt_d;
    end
  end

  assign op_cnt    = opCnt_q;
  assign carry_cnt = carryCnt_q;
`else
  // No statistics hardware: counters read as zero and clr has no effect.
  logic unusedClr;
  assign unusedClr = clr;
  assign op_cnt    = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_ha_gl.sv
// tb_ha_gl: directed self-checking bench for ha_gl (CNT_W=4 so saturation
// is reachable). Counter expectations depend on HA_GL_STATS_EN.
module tb_ha_gl;

`ifdef HA_GL_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       a;
  logic       b;
  logic       en;
  logic       clr;
  logic       sum;
  logic       cout;
  logic       sum_q;
  logic       cout_q;
  logic       valid_q;
  logic [3:0] carryCnt;
  logic [3:0] opCnt;

  int total = 0;
  int bad   = 0;

  ha_gl #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .en        (en),
    .clr       (clr),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .valid_q   (valid_q),
    .carry_cnt (carryCnt),
    .op_cnt    (opCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic aIn, input logic bIn, input logic enIn, input logic clrIn);
    @(negedge clk);
    a   = aIn;
    b   = bIn;
    en  = enIn;
    clr = clrIn;
    @(posedge clk);
    #1;
  endtask

  // Check the registered outputs and (stats-dependent) counters together.
  task automatic checkRegs(input string tag, input logic s, input logic c, input logic v,
                           input logic [3:0] opExp, input logic [3:0] carryExp);
    checkOutput({tag, ".sum_q"},   sum_q,    s);
    checkOutput({tag, ".cout_q"},  cout_q,   c);
    checkOutput({tag, ".valid_q"}, valid_q,  v);
    checkOutput({tag, ".op_cnt"},  opCnt,    Stats ? opExp : 4'd0);
    checkOutput({tag, ".carry"},   carryCnt, Stats ? carryExp : 4'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    #1;
    checkRegs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Exhaustive combinational table while held in reset.
    a = 1'b0; b = 1'b0; #1;
    checkOutput("comb00.sum", sum, 1'b0);
    checkOutput("comb00.cout", cout, 1'b0);
    a = 1'b0; b = 1'b1; #1;
    checkOutput("comb01.sum", sum, 1'b1);
    checkOutput("comb01.cout", cout, 1'b0);
    a = 1'b1; b = 1'b0; #1;
    checkOutput("comb10.sum", sum, 1'b1);
    checkOutput("comb10.cout", cout, 1'b0);
    a = 1'b1; b = 1'b1; #1;
    checkOutput("comb11.sum", sum, 1'b0);
    checkOutput("comb11.cout", cout, 1'b1);

    @(negedge clk);
    a = 1'b0; b = 1'b0;
    reset_n = 1'b1;

    // Registered path: one capture of 1+1, then hold with en low.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkRegs("cap11", 1'b0, 1'b1, 1'b1, 4'd1, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkRegs("hold", 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);

    // clr alone zeroes counters but leaves the result registers alone.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkRegs("clrOnly", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // Counter sequence 00,01,10,11,11.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkRegs("seq00", 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkRegs("seq01", 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkRegs("seq11", 1'b0, 1'b1, 1'b1, 4'd5, 4'd2);

    // clr with a simultaneous carry capture: clear wins, result still loads.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkRegs("preClr", 1'b0, 1'b1, 1'b0, 4'd5, 4'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkRegs("clrEn", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);

    // Saturation at 15 with 20 carry captures.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkRegs("sat15", 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkRegs("sat20", 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkRegs("asyncRst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    a = 1'b1; b = 1'b0; en = 1'b1; #1;
    checkOutput("rstComb.sum", sum, 1'b1);
    checkOutput("rstComb.cout", cout, 1'b0);
    a = 1'b1; b = 1'b1; #1;
    checkOutput("rstComb11.sum", sum, 1'b0);
    checkOutput("rstComb11.cout", cout, 1'b1);
    @(posedge clk);
    #1;
    checkRegs("rstEdge", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Release reset with en low: nothing captured until en rises.
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkRegs("relNoEn", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkRegs("relCap", 1'b0, 1'b1, 1'b1, 4'd1, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
